// File: rtl/if_id_pipe_pkg.sv
// Shared definitions for the pipeline boundary registers (IF/ID, ID/EX, EX/MEM).
// Holds the skid-buffer occupancy encoding and the bubble instruction word.
package if_id_pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

    // Canonical RISC-style NOP encoding presented to decode while the stage holds a bubble
    localparam logic [31:0] PIPE_NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_id_pipe_sat_counter.sv
// Parameterised saturating up-counter with synchronous reset, for performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Holds at all-ones instead of wrapping so long stalls read as "at least max"
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID boundary: two-entry skid buffer between fetch and decode with flush
// and a saturating stall counter. inReady is registered to cut the ready path.
module if_id_pipe
    import if_id_pipe_pkg::*;
#(
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(PIPE_NOP_WORD),
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] inInstruction,
    input  logic [DATA_W-1:0] inPostPc,
    input  logic              inValid,
    output logic              inReady,
    input  logic              flush,
    output logic [DATA_W-1:0] outInstruction,
    output logic [DATA_W-1:0] outPostPc,
    output logic              outValid,
    input  logic              outReady,
    output logic [CNT_W-1:0]  stallCount
);

    occ_state_t        r_state;
    logic              r_inReady;
    logic [DATA_W-1:0] r_headInstr;
    logic [DATA_W-1:0] r_headPc;
    logic [DATA_W-1:0] r_skidInstr;
    logic [DATA_W-1:0] r_skidPc;

    logic w_push;
    logic w_pop;
    logic w_outValid;
    logic w_stall;

    assign w_outValid = (r_state != OCC_EMPTY);
    assign w_push     = inValid & r_inReady;
    assign w_pop      = w_outValid & outReady;
    assign w_stall    = w_outValid & ~outReady;

    // r_inReady tracks (next state != TWO) so it is ready the same cycle the state lands
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= OCC_EMPTY;
            r_inReady   <= 1'b1;
            r_headInstr <= '0;
            r_headPc    <= '0;
            r_skidInstr <= '0;
            r_skidPc    <= '0;
        end else if (flush) begin
            r_state   <= OCC_EMPTY;
            r_inReady <= 1'b1;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_push) begin
                        r_headInstr <= inInstruction;
                        r_headPc    <= inPostPc;
                        r_state     <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (w_push && !w_pop) begin
                        r_skidInstr <= inInstruction;
                        r_skidPc    <= inPostPc;
                        r_state     <= OCC_TWO;
                        r_inReady   <= 1'b0;
                    end else if (w_push && w_pop) begin
                        r_headInstr <= inInstruction;
                        r_headPc    <= inPostPc;
                    end else if (w_pop) begin
                        r_state <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (w_pop) begin
                        r_headInstr <= r_skidInstr;
                        r_headPc    <= r_skidPc;
                        r_state     <= OCC_ONE;
                        r_inReady   <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= OCC_EMPTY;
                    r_inReady <= 1'b1;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stallCounter (
        .clk  (clk),
        .reset(reset),
        .inc  (w_stall),
        .count(stallCount)
    );

    assign inReady        = r_inReady;
    assign outValid       = w_outValid;
    assign outInstruction = w_outValid ? r_headInstr : NOP_WORD;
    assign outPostPc      = w_outValid ? r_headPc : '0;

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed self-checking bench for if_id_pipe: reset, streaming, back-pressure,
// flush and stall-counter saturation (counter built 4 bits wide).
module tb_if_id_pipe;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] inInstruction;
    logic [DATA_W-1:0] inPostPc;
    logic              inValid;
    logic              inReady;
    logic              flush;
    logic [DATA_W-1:0] outInstruction;
    logic [DATA_W-1:0] outPostPc;
    logic              outValid;
    logic              outReady;
    logic [CNT_W-1:0]  stallCount;

    int checkCount = 0;
    int errorCount = 0;

    if_id_pipe #(
        .DATA_W  (DATA_W),
        .NOP_WORD(32'h0000_0000),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .inInstruction (inInstruction),
        .inPostPc      (inPostPc),
        .inValid       (inValid),
        .inReady       (inReady),
        .flush         (flush),
        .outInstruction(outInstruction),
        .outPostPc     (outPostPc),
        .outValid      (outValid),
        .outReady      (outReady),
        .stallCount    (stallCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic oReady, input logic fl);
        inValid       = valid;
        inInstruction = instr;
        inPostPc      = pc;
        outReady      = oReady;
        flush         = fl;
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst_outValid", {31'b0, outValid}, 32'd0);
        checkOutput("rst_inReady", {31'b0, inReady}, 32'd1);
        checkOutput("rst_outInstr", outInstruction, 32'h0000_0000);
        checkOutput("rst_outPc", outPostPc, 32'h0);
        checkOutput("rst_stall", 32'(stallCount), 32'd0);

        // Reset mid-stream: fill to TWO, then reset
        applyStimulus(1'b1, 32'h8C01_0004, 32'h0000_0008, 1'b0, 1'b0);
        tick();
        checkOutput("mid_headA", outInstruction, 32'h8C01_0004);
        applyStimulus(1'b1, 32'h0022_1820, 32'h0000_000C, 1'b0, 1'b0);
        tick();
        checkOutput("mid_full_inReady", {31'b0, inReady}, 32'd0);
        checkOutput("mid_stall", 32'(stallCount), 32'd1);
        doReset();
        checkOutput("mid_rst_outValid", {31'b0, outValid}, 32'd0);
        checkOutput("mid_rst_inReady", {31'b0, inReady}, 32'd1);
        checkOutput("mid_rst_outInstr", outInstruction, 32'h0000_0000);
        checkOutput("mid_rst_stall", 32'(stallCount), 32'd0);

        // Streaming with outReady held high
        applyStimulus(1'b1, 32'h2001_0005, 32'h0000_0004, 1'b1, 1'b0);
        tick();
        checkOutput("str_w1", outInstruction, 32'h2001_0005);
        checkOutput("str_w1_pc", outPostPc, 32'h0000_0004);
        applyStimulus(1'b1, 32'h2002_0003, 32'h0000_0008, 1'b1, 1'b0);
        tick();
        checkOutput("str_w2", outInstruction, 32'h2002_0003);
        checkOutput("str_w2_pc", outPostPc, 32'h0000_0008);
        checkOutput("str_inReady", {31'b0, inReady}, 32'd1);
        applyStimulus(1'b1, 32'h0022_1820, 32'h0000_000C, 1'b1, 1'b0);
        tick();
        checkOutput("str_w3", outInstruction, 32'h0022_1820);
        checkOutput("str_w3_pc", outPostPc, 32'h0000_000C);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("str_drained", {31'b0, outValid}, 32'd0);
        checkOutput("str_stall", 32'(stallCount), 32'd0);

        // Back-pressure: A, B fill the buffer, C waits upstream
        doReset();
        applyStimulus(1'b1, 32'hAAAA_0001, 32'h0000_0104, 1'b0, 1'b0);
        tick();
        checkOutput("bp_headA", outInstruction, 32'hAAAA_0001);
        checkOutput("bp_inReady_one", {31'b0, inReady}, 32'd1);
        applyStimulus(1'b1, 32'hBBBB_0002, 32'h0000_0108, 1'b0, 1'b0);
        tick();
        checkOutput("bp_inReady_two", {31'b0, inReady}, 32'd0);
        checkOutput("bp_holdA", outInstruction, 32'hAAAA_0001);
        applyStimulus(1'b1, 32'hCCCC_0003, 32'h0000_010C, 1'b0, 1'b0);
        tick();
        checkOutput("bp_stillA", outInstruction, 32'hAAAA_0001);
        checkOutput("bp_stall2", 32'(stallCount), 32'd2);
        applyStimulus(1'b1, 32'hCCCC_0003, 32'h0000_010C, 1'b1, 1'b0);
        tick();
        checkOutput("bp_deliverB", outInstruction, 32'hBBBB_0002);
        checkOutput("bp_deliverB_pc", outPostPc, 32'h0000_0108);
        checkOutput("bp_inReady_back", {31'b0, inReady}, 32'd1);
        tick();
        checkOutput("bp_deliverC", outInstruction, 32'hCCCC_0003);
        checkOutput("bp_deliverC_pc", outPostPc, 32'h0000_010C);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("bp_empty", {31'b0, outValid}, 32'd0);
        checkOutput("bp_stall_final", 32'(stallCount), 32'd2);

        // Flush while full with a concurrent push attempt
        doReset();
        applyStimulus(1'b1, 32'h1111_0001, 32'h0000_0204, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h2222_0002, 32'h0000_0208, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h3333_0003, 32'h0000_020C, 1'b0, 1'b1);
        tick();
        checkOutput("fl_outValid", {31'b0, outValid}, 32'd0);
        checkOutput("fl_inReady", {31'b0, inReady}, 32'd1);
        checkOutput("fl_outInstr", outInstruction, 32'h0000_0000);
        checkOutput("fl_stall", 32'(stallCount), 32'd2);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("fl_no_ghost", {31'b0, outValid}, 32'd0);

        // Flush coinciding with a pop from ONE
        doReset();
        applyStimulus(1'b1, 32'h4444_0004, 32'h0000_0304, 1'b1, 1'b0);
        tick();
        checkOutput("flp_head", outInstruction, 32'h4444_0004);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        checkOutput("flp_outValid", {31'b0, outValid}, 32'd0);
        checkOutput("flp_stall", 32'(stallCount), 32'd0);

        // Saturation of the 4-bit stall counter
        doReset();
        applyStimulus(1'b1, 32'h5555_0005, 32'h0000_0404, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 14) checkOutput("sat_14", 32'(stallCount), 32'd14);
            if (k == 15) checkOutput("sat_15", 32'(stallCount), 32'd15);
            if (k == 20) checkOutput("sat_hold", 32'(stallCount), 32'd15);
        end
        checkOutput("sat_valid", {31'b0, outValid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
